vga_fb_arbiter: RTL and testbench
=================================

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 Parameter ADDR_W, default 19, framebuffer address width.
REQ-004 Parameter FIFO_DEPTH, default 4, write FIFO entries (power of two, >=2).
REQ-005 i_clk  in  1  pixel clock; all logic on rising edge.
REQ-006 i_rst_n  in  1  synchronous active-low reset, sampled on rising i_clk.
REQ-007 i_hblank  in  1  horizontal blank from hsync timing block.
REQ-008 i_vblank  in  1  vertical blank from vsync timing block.
REQ-009 i_wr_valid / o_wr_ready  in/out  1/1  writer handshake; transfer when both high on a rising edge.
REQ-010 i_wr_addr  in  ADDR_W  pixel address, y*H_ACTIVE+x.
REQ-011 i_wr_data  in  3  pixel {r,g,b}.
REQ-012 o_wr_err  out  1  one-cycle pulse: accepted write had out-of-range address, dropped.
REQ-013 o_mem_en, o_mem_we  out  1/1  single-port RAM enable, write enable.
REQ-014 o_mem_addr  out  ADDR_W; o_mem_wdata  out  3; i_mem_rdata  in  3 (read latency exactly 1 cycle).
REQ-015 o_red, o_grn, o_blu  out  1 each  displayed pixel.
REQ-016 o_fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-017 active = !i_hblank && !i_vblank, evaluated each cycle.
REQ-018 FSM states: WAIT_FRAME, RUN; reset enters WAIT_FRAME.
REQ-019 WAIT_FRAME -> RUN on first cycle with i_vblank=1; no scanout reads in WAIT_FRAME; writes are serviced every cycle.
REQ-020 RUN: scan address counter resets to 0 every cycle with i_vblank=1; increments by 1 after each active cycle.
REQ-021 Scan counter at H_ACTIVE*V_ACTIVE-1 followed by another active cycle wraps to 0 (no out-of-range read).
REQ-022 Arbitration per cycle: RUN && active -> scanout read (o_mem_en=1, o_mem_we=0, o_mem_addr=scan counter); scanout always wins.
REQ-023 Otherwise, FIFO non-empty -> pop head, o_mem_en=1, o_mem_we=1, address/data from head; else o_mem_en=0.
REQ-024 Memory outputs are combinational from state/FIFO head, registered inputs only; at most one access per cycle.
REQ-025 Pixel output: {o_red,o_grn,o_blu} <= i_mem_rdata one cycle after a scanout read; 3'b000 in every cycle not following a scanout read (blanking black).
REQ-026 Displayed pixel lags timing-block active window by exactly 1 cycle.
REQ-027 o_wr_ready = !full; independent of same-cycle pop.
REQ-028 Accepted write with i_wr_addr >= H_ACTIVE*V_ACTIVE: not pushed, o_wr_err=1 next cycle.
REQ-029 Simultaneous push and pop: level unchanged, order preserved (FIFO strict in-order).
REQ-030 Push into empty FIFO becomes eligible for pop the following cycle (1-cycle minimum write latency).
REQ-031 i_hblank/i_vblank glitch-free and synchronous to i_clk; no internal synchronisers.

Reset
REQ-032 While i_rst_n=0 at a rising edge: state WAIT_FRAME, scan counter 0, FIFO empty, o_fifo_level 0, o_wr_ready 0, o_wr_err 0, o_mem_en 0, o_mem_we 0, rgb 3'b000.
REQ-033 o_wr_ready rises the first cycle after i_rst_n samples 1.
REQ-034 Reset mid-line or mid-write discards FIFO contents and any in-flight read data; no memory write issued in the reset cycle.

Verification
REQ-035 Reset release, i_vblank=0 -> no reads until first vblank cycle; then first active cycle reads addr 0, second addr 1.
REQ-036 Full line: 640 active cycles from frame start -> addresses 0..639 issued, rgb equals model RAM data delayed 1 cycle, 000 during hblank.
REQ-037 FIFO fill during active: 5 writes offered -> 4 accepted, o_wr_ready=0, o_fifo_level=4; at hblank 4 writes issued in order over 4 cycles, level reaches 0.
REQ-038 Write addr 307200 -> o_wr_err pulse one cycle, level unchanged, no memory write.
REQ-039 Push and pop same cycle at level 2 -> level stays 2, write data order matches push order.
REQ-040 Assert i_rst_n=0 with level 3 mid-line -> next cycle level 0, o_mem_en=0, rgb 000, state WAIT_FRAME.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// vga_fb_arbiter
//   Shares one single-port framebuffer RAM between VGA scanout and a pixel
//   writer. Scanout reads have absolute priority during the active window;
//   writer requests are queued in a small in-order FIFO and drained whenever
//   the RAM is not needed for scanout (blanking, or before the first frame).
//
// Ports
//   i_clk, i_rst_n          pixel clock, synchronous active-low reset
//   i_hblank, i_vblank      blanking flags from the timing block
//   i_wr_valid/o_wr_ready   writer handshake
//   i_wr_addr, i_wr_data    pixel address (y*H_ACTIVE+x) and {r,g,b}
//   o_wr_err                1-cycle pulse: accepted write was out of range
//   o_mem_en/we/addr/wdata  RAM request, combinational from registered state
//   i_mem_rdata             RAM read data, 1-cycle latency
//   o_red/o_grn/o_blu       displayed pixel (black when not scanning)
//   o_fifo_level            write FIFO occupancy
// ---------------------------------------------------------------------------
module vga_fb_arbiter #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int ADDR_W     = 19,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_hblank,
    input  logic                          i_vblank,
    input  logic                          i_wr_valid,
    output logic                          o_wr_ready,
    input  logic [ADDR_W-1:0]             i_wr_addr,
    input  logic [2:0]                    i_wr_data,
    output logic                          o_wr_err,
    output logic                          o_mem_en,
    output logic                          o_mem_we,
    output logic [ADDR_W-1:0]             o_mem_addr,
    output logic [2:0]                    o_mem_wdata,
    input  logic [2:0]                    i_mem_rdata,
    output logic                          o_red,
    output logic                          o_grn,
    output logic                          o_blu,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

    localparam int                PTR_W     = $clog2(FIFO_DEPTH);
    localparam int                FB_SIZE   = H_ACTIVE * V_ACTIVE;
    localparam logic [ADDR_W:0]   FB_SIZE_W = (ADDR_W+1)'(FB_SIZE);
    localparam logic [ADDR_W-1:0] SCAN_LAST = ADDR_W'(FB_SIZE - 1);
    localparam logic [PTR_W:0]    DEPTH_W   = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        RUN        = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_scan_cnt;
    logic                r_rd_d;
    logic                r_rdy_en;
    logic                r_wr_err;
    logic [PTR_W:0]      r_wr_ptr;
    logic [PTR_W:0]      r_rd_ptr;
    logic [ADDR_W-1:0]   r_fifo_addr [FIFO_DEPTH];
    logic [2:0]          r_fifo_data [FIFO_DEPTH];

    logic                w_active;
    logic                w_scan_rd;
    logic [PTR_W:0]      w_level;
    logic                w_empty;
    logic                w_full;
    logic                w_wr_fire;
    logic                w_addr_ok;
    logic                w_push;
    logic                w_pop;

    assign w_active  = !i_hblank && !i_vblank;
    // Requests are masked by reset so nothing reaches the RAM in a reset cycle.
    assign w_scan_rd = i_rst_n && (r_state == RUN) && w_active;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_level   = r_wr_ptr - r_rd_ptr;
    assign w_empty   = (w_level == '0);
    assign w_full    = (w_level == DEPTH_W);

    // r_rdy_en holds ready low until the first cycle after reset is released.
    assign o_wr_ready = r_rdy_en && !w_full;
    assign w_wr_fire  = i_wr_valid && o_wr_ready;
    assign w_addr_ok  = ({1'b0, i_wr_addr} < FB_SIZE_W);
    assign w_push     = w_wr_fire && w_addr_ok;
    assign w_pop      = i_rst_n && !w_scan_rd && !w_empty;

    assign o_fifo_level = w_level;
    assign o_wr_err     = r_wr_err;

    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (w_scan_rd) begin
            o_mem_en   = 1'b1;
            o_mem_addr = r_scan_cnt;
        end else if (w_pop) begin
            o_mem_en    = 1'b1;
            o_mem_we    = 1'b1;
            o_mem_addr  = r_fifo_addr[r_rd_ptr[PTR_W-1:0]];
            o_mem_wdata = r_fifo_data[r_rd_ptr[PTR_W-1:0]];
        end
    end

    // RAM data lands the cycle after the read, so gating it with the delayed
    // read flag gives exactly one cycle of lag and black everywhere else.
    assign {o_red, o_grn, o_blu} = r_rd_d ? i_mem_rdata : 3'b000;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= WAIT_FRAME;
            r_scan_cnt <= '0;
            r_rd_d     <= 1'b0;
            r_rdy_en   <= 1'b0;
            r_wr_err   <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_rdy_en <= 1'b1;
            r_wr_err <= w_wr_fire && !w_addr_ok;
            r_rd_d   <= w_scan_rd;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
            end

            case (r_state)
                WAIT_FRAME: begin
                    r_scan_cnt <= '0;
                    if (i_vblank) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (i_vblank) begin
                        r_scan_cnt <= '0;
                    end else if (w_active) begin
                        r_scan_cnt <= (r_scan_cnt == SCAN_LAST) ? '0
                                    : r_scan_cnt + ADDR_W'(1);
                    end
                end
                default: r_state <= WAIT_FRAME;
            endcase
        end
    end

    // Payload storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr[PTR_W-1:0]] <= i_wr_addr;
            r_fifo_data[r_wr_ptr[PTR_W-1:0]] <= i_wr_data;
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vga_fb_arbiter
//   Self-checking bench for vga_fb_arbiter: a vector table for the startup
//   sequence, then scoreboard-driven full line, FIFO fill/drain, push+pop and
//   mid-line reset sequences, plus frame wrap on a tiny-geometry instance.
// ---------------------------------------------------------------------------
module tb_vga_fb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        hb, vb, wv;
    logic [18:0] wa;
    logic [2:0]  wd;
    logic        wr_ready, wr_err, mem_en, mem_we;
    logic [18:0] mem_addr;
    logic [2:0]  mem_wdata, mem_rdata;
    logic        red, grn, blu;
    logic [2:0]  fifo_level;

    logic        s_hb, s_vb, s_wv;
    logic [3:0]  s_wa;
    logic [2:0]  s_wd, s_rdata;
    logic        s_ready, s_err, s_en, s_we;
    logic [3:0]  s_addr;
    logic [2:0]  s_wdata;
    logic        s_r, s_g, s_b;
    logic [1:0]  s_level;

    int n_chk  = 0;
    int n_pass = 0;

    vga_fb_arbiter dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_hblank(hb), .i_vblank(vb),
        .i_wr_valid(wv), .o_wr_ready(wr_ready), .i_wr_addr(wa), .i_wr_data(wd),
        .o_wr_err(wr_err), .o_mem_en(mem_en), .o_mem_we(mem_we),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
        .o_red(red), .o_grn(grn), .o_blu(blu), .o_fifo_level(fifo_level)
    );

    vga_fb_arbiter #(.H_ACTIVE(4), .V_ACTIVE(2), .ADDR_W(4), .FIFO_DEPTH(2)) u_small (
        .i_clk(clk), .i_rst_n(rst_n), .i_hblank(s_hb), .i_vblank(s_vb),
        .i_wr_valid(s_wv), .o_wr_ready(s_ready), .i_wr_addr(s_wa), .i_wr_data(s_wd),
        .o_wr_err(s_err), .o_mem_en(s_en), .o_mem_we(s_we),
        .o_mem_addr(s_addr), .o_mem_wdata(s_wdata), .i_mem_rdata(s_rdata),
        .o_red(s_r), .o_grn(s_g), .o_blu(s_b), .o_fifo_level(s_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] ram_f(input logic [18:0] a);
        return a[2:0] ^ a[5:3] ^ 3'b101;
    endfunction

    // Model RAM: contents are a fixed function of address, 1-cycle read.
    initial mem_rdata = 3'b000;
    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= ram_f(mem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        hb, vb, wv;
        logic [18:0] wa;
        logic [2:0]  wd;
        logic        e_en, e_we;
        logic [18:0] e_addr;
        logic [2:0]  e_wd;
        logic        e_rdy;
        logic [2:0]  e_lvl;
        logic        e_err;
        logic [2:0]  e_rgb;
    } vec_t;

    vec_t tbl [14];

    function automatic vec_t mk(input logic h, input logic v, input logic w,
                                input logic [18:0] a, input logic [2:0] d,
                                input logic en, input logic we, input logic [18:0] ea,
                                input logic [2:0] ed, input logic rdy, input logic [2:0] lvl,
                                input logic err, input logic [2:0] rgb);
        vec_t t;
        t.hb = h; t.vb = v; t.wv = w; t.wa = a; t.wd = d;
        t.e_en = en; t.e_we = we; t.e_addr = ea; t.e_wd = ed;
        t.e_rdy = rdy; t.e_lvl = lvl; t.e_err = err; t.e_rgb = rgb;
        return t;
    endfunction

    // ---------------- scoreboard model ----------------
    logic        m_run, m_rdy, m_err;
    logic [18:0] m_cnt;
    logic [21:0] sb_wr [$];
    logic [2:0]  sb_rgb [$];

    task automatic model_reset();
        m_run = 1'b0; m_rdy = 1'b0; m_err = 1'b0; m_cnt = '0;
        sb_wr.delete(); sb_rgb.delete();
        sb_rgb.push_back(3'b000);
    endtask

    task automatic cyc(input logic r, input logic h, input logic v, input logic w,
                       input logic [18:0] a, input logic [2:0] d);
        logic        act, e_read, e_rdy;
        logic [2:0]  e_rgb;
        logic [21:0] head;
        @(posedge clk); #1;
        rst_n = r; hb = h; vb = v; wv = w; wa = a; wd = d;
        #1;
        act   = !h && !v;
        e_rdy = m_rdy && (sb_wr.size() < 4);
        chk("wr_ready", 32'(wr_ready), 32'(e_rdy));
        chk("fifo_level", 32'(fifo_level), 32'(sb_wr.size()));
        chk("wr_err", 32'(wr_err), 32'(m_err));
        e_rgb = (sb_rgb.size() > 0) ? sb_rgb.pop_front() : 3'b000;
        chk("rgb", 32'({red, grn, blu}), 32'(e_rgb));
        if (!r) begin
            chk("rst_mem_en", 32'(mem_en), 32'(0));
            model_reset();
        end else begin
            e_read = m_run && act;
            if (e_read) begin
                chk("rd_en", 32'(mem_en), 32'(1));
                chk("rd_we", 32'(mem_we), 32'(0));
                chk("rd_addr", 32'(mem_addr), 32'(m_cnt));
                sb_rgb.push_back(ram_f(m_cnt));
            end else begin
                sb_rgb.push_back(3'b000);
                if (sb_wr.size() > 0) begin
                    head = sb_wr.pop_front();
                    chk("wr_en", 32'(mem_en), 32'(1));
                    chk("wr_we", 32'(mem_we), 32'(1));
                    chk("wr_addr", 32'(mem_addr), 32'(head[21:3]));
                    chk("wr_data", 32'(mem_wdata), 32'(head[2:0]));
                end else begin
                    chk("idle_en", 32'(mem_en), 32'(0));
                end
            end
            m_err = w && e_rdy && (a >= 19'd307200);
            if (w && e_rdy && (a < 19'd307200)) sb_wr.push_back({a, d});
            if (m_run) begin
                if (v) m_cnt = '0;
                else if (act) m_cnt = (m_cnt == 19'd307199) ? 19'd0 : m_cnt + 19'd1;
            end else if (v) begin
                m_run = 1'b1;
            end
            m_rdy = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; hb = 1'b1; vb = 1'b0; wv = 1'b0; wa = '0; wd = '0;
        s_hb = 1'b1; s_vb = 1'b0; s_wv = 1'b0; s_wa = '0; s_wd = '0; s_rdata = 3'b000;

        //           hb    vb    wv    wa            wd    en    we    addr       wd    rdy   lvl   err   rgb
        tbl[0]  = mk(1'b0, 1'b0, 1'b1, 19'd100,    3'd5, 1'b0, 1'b0, 19'd0,   3'd0, 1'b1, 3'd0, 1'b0, 3'd0);
        tbl[1]  = mk(1'b0, 1'b0, 1'b0, 19'd0,      3'd0, 1'b1, 1'b1, 19'd100, 3'd5, 1'b1, 3'd1, 1'b0, 3'd0);
        tbl[2]  = mk(1'b0, 1'b0, 1'b1, 19'd307200, 3'd3, 1'b0, 1'b0, 19'd0,   3'd0, 1'b1, 3'd0, 1'b0, 3'd0);
        tbl[3]  = mk(1'b0, 1'b0, 1'b0, 19'd0,      3'd0, 1'b0, 1'b0, 19'd0,   3'd0, 1'b1, 3'd0, 1'b1, 3'd0);
        tbl[4]  = mk(1'b1, 1'b1, 1'b0, 19'd0,      3'd0, 1'b0, 1'b0, 19'd0,   3'd0, 1'b1, 3'd0, 1'b0, 3'd0);
        tbl[5]  = mk(1'b0, 1'b0, 1'b0, 19'd0,      3'd0, 1'b1, 1'b0, 19'd0,   3'd0, 1'b1, 3'd0, 1'b0, 3'd0);
        tbl[6]  = mk(1'b0, 1'b0, 1'b0, 19'd0,      3'd0, 1'b1, 1'b0, 19'd1,   3'd0, 1'b1, 3'd0, 1'b0, 3'd5);
        tbl[7]  = mk(1'b1, 1'b0, 1'b0, 19'd0,      3'd0, 1'b0, 1'b0, 19'd0,   3'd0, 1'b1, 3'd0, 1'b0, 3'd4);
        tbl[8]  = mk(1'b1, 1'b0, 1'b1, 19'd7,      3'd6, 1'b0, 1'b0, 19'd0,   3'd0, 1'b1, 3'd0, 1'b0, 3'd0);
        tbl[9]  = mk(1'b0, 1'b0, 1'b1, 19'd8,      3'd1, 1'b1, 1'b0, 19'd2,   3'd0, 1'b1, 3'd1, 1'b0, 3'd0);
        tbl[10] = mk(1'b1, 1'b0, 1'b0, 19'd0,      3'd0, 1'b1, 1'b1, 19'd7,   3'd6, 1'b1, 3'd2, 1'b0, 3'd7);
        tbl[11] = mk(1'b1, 1'b0, 1'b0, 19'd0,      3'd0, 1'b1, 1'b1, 19'd8,   3'd1, 1'b1, 3'd1, 1'b0, 3'd0);
        tbl[12] = mk(1'b1, 1'b1, 1'b0, 19'd0,      3'd0, 1'b0, 1'b0, 19'd0,   3'd0, 1'b1, 3'd0, 1'b0, 3'd0);
        tbl[13] = mk(1'b0, 1'b0, 1'b0, 19'd0,      3'd0, 1'b1, 1'b0, 19'd0,   3'd0, 1'b1, 3'd0, 1'b0, 3'd0);

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_ready", 32'(wr_ready), 32'(0));
        chk("rst_level", 32'(fifo_level), 32'(0));
        chk("rst_err", 32'(wr_err), 32'(0));
        chk("rst_en", 32'(mem_en), 32'(0));
        chk("rst_rgb", 32'({red, grn, blu}), 32'(0));

        // Release cycle: ready must still be low, no read while waiting for a frame
        @(posedge clk); #1;
        rst_n = 1'b1; hb = 1'b0; vb = 1'b0;
        #1;
        chk("rel_ready", 32'(wr_ready), 32'(0));
        chk("rel_en", 32'(mem_en), 32'(0));

        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            hb = tbl[i].hb; vb = tbl[i].vb; wv = tbl[i].wv; wa = tbl[i].wa; wd = tbl[i].wd;
            #1;
            chk($sformatf("tbl%0d_en", i), 32'(mem_en), 32'(tbl[i].e_en));
            if (tbl[i].e_en) begin
                chk($sformatf("tbl%0d_we", i), 32'(mem_we), 32'(tbl[i].e_we));
                chk($sformatf("tbl%0d_addr", i), 32'(mem_addr), 32'(tbl[i].e_addr));
                if (tbl[i].e_we)
                    chk($sformatf("tbl%0d_wdata", i), 32'(mem_wdata), 32'(tbl[i].e_wd));
            end
            chk($sformatf("tbl%0d_ready", i), 32'(wr_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_level", i), 32'(fifo_level), 32'(tbl[i].e_lvl));
            chk($sformatf("tbl%0d_err", i), 32'(wr_err), 32'(tbl[i].e_err));
            chk($sformatf("tbl%0d_rgb", i), 32'({red, grn, blu}), 32'(tbl[i].e_rgb));
        end

        // Scoreboard phase: bring everything back to a known reset state
        @(posedge clk); #1;
        rst_n = 1'b0; hb = 1'b1; vb = 1'b0; wv = 1'b0;
        model_reset();
        sb_rgb.delete();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 19'd0, 3'd0);
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 19'd0, 3'd0);
        repeat (2) cyc(1'b1, 1'b1, 1'b1, 1'b0, 19'd0, 3'd0);

        // Full line with writes offered mid-line: 4 fit, the rest are refused
        for (int i = 0; i < 640; i++) begin
            if (i >= 10 && i < 16)
                cyc(1'b1, 1'b0, 1'b0, 1'b1, 19'(1000 + i), 3'(i));
            else
                cyc(1'b1, 1'b0, 1'b0, 1'b0, 19'd0, 3'd0);
        end
        chk("fill_level", 32'(fifo_level), 32'(4));
        chk("fill_ready", 32'(wr_ready), 32'(0));
        repeat (6) cyc(1'b1, 1'b1, 1'b0, 1'b0, 19'd0, 3'd0);
        chk("drain_level", 32'(fifo_level), 32'(0));

        // Push and pop together at level 2
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 19'd2000, 3'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 19'd2001, 3'd2);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 19'd2002, 3'd3);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 19'd0, 3'd0);
        chk("pushpop_level", 32'(fifo_level), 32'(2));
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0, 19'd0, 3'd0);

        // Reset mid-line with three writes pending
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 19'd3000, 3'd4);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 19'd3001, 3'd5);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 19'd3002, 3'd6);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 19'd0, 3'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 19'd0, 3'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 19'd0, 3'd0);
        chk("midrst_level", 32'(fifo_level), 32'(0));
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0, 19'd0, 3'd0);

        // Frame wrap on the 4x2 instance: addresses 0..7 then 0,1
        @(posedge clk); #1;
        s_hb = 1'b1; s_vb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            s_hb = 1'b0; s_vb = 1'b0;
            #1;
            chk($sformatf("wrap%0d_en", i), 32'(s_en), 32'(1));
            chk($sformatf("wrap%0d_we", i), 32'(s_we), 32'(0));
            chk($sformatf("wrap%0d_addr", i), 32'(s_addr), 32'(i % 8));
        end
        @(posedge clk); #1;
        s_hb = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
